// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch stage.
//   state_e         - fetch FSM encoding (LOAD / FETCH / HALT)
//   BYTES_PER_WORD  - bytes per instruction for the default 32-bit word
//   bytes_per_word  - bytes per instruction for an arbitrary word width
//   align_mask      - low-address mask that must be zero for a word-aligned PC
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Word size is a power of two, so bpw-1 covers exactly the low log2(bpw) bits.
  function automatic int unsigned align_mask(input int unsigned data_w);
    return (data_w / 8) - 1;
  endfunction

endpackage

// File: rtl/fetch_unit_rom.sv
// byte_rom: 2^ADDR_W x 8 byte store with a synchronous byte write port and a
// combinational little-endian word read. Byte k of the word comes from
// address raddr+k, wrapping modulo 2^ADDR_W. Contents are never reset.
//   clk    - write clock
//   we     - byte write enable
//   waddr  - byte write address
//   wdata  - byte to write
//   raddr  - byte address of word byte 0
//   rdata  - assembled word, byte k in bits [8k+7:8k]
module byte_rom
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int BPW = int'(bytes_per_word(DATA_W));

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // One read lane per byte; the ADDR_W-wide sum gives the wrap for free.
  for (genvar k = 0; k < BPW; k++) begin : g_lane
    logic [ADDR_W-1:0] a;
    assign a               = raddr + ADDR_W'(k);
    assign rdata[8*k +: 8] = mem[a];
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the program loader and decode.
// Holds the PC, a byte-addressed instruction store (loaded through the prog_*
// port while prog_en=1) and a registered instruction output with valid/ready.
//   clk, reset      - clock; asynchronous active-low reset
//   prog_en/we/addr/data - loader port; prog_en forces LOAD
//   redirect_valid/pc    - taken branch/jump; flushes the output register
//   instr_valid/ready    - output handshake towards decode
//   instr, instr_pc      - fetched word and its byte address
//   pc_next              - PC + word bytes (combinational, wraps)
//   fault                - sticky misaligned-redirect flag
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] RPC   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(bytes_per_word(DATA_W));
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(align_mask(DATA_W));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              vld_q, vld_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] word;
  logic              misaligned;

  byte_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rom (
    .clk   (clk),
    .we    (prog_en & prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (word)
  );

  assign pc_next    = pc_q + STEP;
  assign misaligned = |(redirect_pc & AMASK);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_LOAD: begin
        if (!prog_en) begin
          state_d = ST_FETCH;
          pc_d    = RPC;
        end
      end
      ST_FETCH: begin
        if (prog_en) begin
          state_d = ST_LOAD;
          vld_d   = 1'b0;
          pc_d    = RPC;
        end else if (redirect_valid) begin
          // Flush wins over any same-cycle accept; a held word is dropped.
          vld_d = 1'b0;
          if (misaligned) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (!vld_q || instr_ready) begin
          instr_d = word;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_next;
        end
      end
      ST_HALT: begin
        // Only the loader gets us out; fault stays set until reset.
        if (prog_en) begin
          state_d = ST_LOAD;
          pc_d    = RPC;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      pc_q    <= RPC;
      instr_q <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
    end
  end

  assign instr_valid = vld_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Two instances share all inputs: "a" is 32-bit wide
// with reset PC 0, "b" is 64-bit wide with reset PC 0x20. Both are tracked by
// a behavioural model (byte array + per-instance PC/output state) and also
// checked against hand-computed constants for the directed scenarios.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog_en = 1'b1, prog_we = 1'b0;
  logic [7:0] prog_addr = '0, prog_data = '0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       instr_ready = 1'b0;

  logic        a_vld, b_vld, a_fault, b_fault;
  logic [31:0] a_instr;
  logic [63:0] b_instr;
  logic [7:0]  a_ipc, b_ipc, a_pcn, b_pcn;

  int unsigned checks = 0, failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_W(32), .ADDR_W(8), .RESET_PC(0)) dut_a (
    .clk(clk), .reset(reset), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(a_vld), .instr_ready(instr_ready), .instr(a_instr),
    .instr_pc(a_ipc), .pc_next(a_pcn), .fault(a_fault));

  fetch_unit #(.DATA_W(64), .ADDR_W(8), .RESET_PC(32'h20)) dut_b (
    .clk(clk), .reset(reset), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(b_vld), .instr_ready(instr_ready), .instr(b_instr),
    .instr_pc(b_ipc), .pc_next(b_pcn), .fault(b_fault));

  // ---------------- reference model ----------------
  // mode: 0 = loading, 1 = running, 2 = halted after a bad redirect
  logic [7:0]  mmem [256];
  int          m_mode [2];
  logic [7:0]  m_pc [2], m_ipc [2];
  logic [63:0] m_instr [2];
  logic        m_vld [2], m_fault [2];

  function automatic int nb(int i);   return (i == 0) ? 4 : 8; endfunction
  function automatic int rstpc(int i); return (i == 0) ? 0 : 'h20; endfunction

  function automatic logic [63:0] mword(logic [7:0] pc, int n);
    logic [63:0] w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = mmem[8'((int'(pc) + k) % 256)];
    return w;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_pc[i] = 8'(rstpc(i)); m_ipc[i] = 0;
      m_instr[i] = 0; m_vld[i] = 0; m_fault[i] = 0;
    end
  endfunction

  function automatic void m_step();
    for (int i = 0; i < 2; i++) begin
      if (m_mode[i] == 0) begin
        if (!prog_en) begin m_mode[i] = 1; m_pc[i] = 8'(rstpc(i)); end
      end else if (m_mode[i] == 2) begin
        if (prog_en) begin m_mode[i] = 0; m_pc[i] = 8'(rstpc(i)); end
      end else if (prog_en) begin
        m_mode[i] = 0; m_vld[i] = 0; m_pc[i] = 8'(rstpc(i));
      end else if (redirect_valid) begin
        m_vld[i] = 0;
        if (int'(redirect_pc) % nb(i) != 0) begin m_mode[i] = 2; m_fault[i] = 1; end
        else m_pc[i] = redirect_pc;
      end else if (!m_vld[i] || instr_ready) begin
        m_instr[i] = mword(m_pc[i], nb(i));
        m_ipc[i]   = m_pc[i];
        m_vld[i]   = 1;
        m_pc[i]    = 8'((int'(m_pc[i]) + nb(i)) % 256);
      end
    end
    if (prog_en && prog_we) mmem[prog_addr] = prog_data;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else m_step();
  end

  function automatic logic [49:0] expa();
    return {m_vld[0], m_instr[0][31:0], m_ipc[0], 8'(m_pc[0] + 8'd4), m_fault[0]};
  endfunction
  function automatic logic [81:0] expb();
    return {m_vld[1], m_instr[1], m_ipc[1], 8'(m_pc[1] + 8'd8), m_fault[1]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({a_vld, a_instr, a_ipc, a_pcn, a_fault} !== {1'b0, 32'h0, 8'h00, 8'h04, 1'b0}) begin
      failures++; $display("FAIL reset_a got=%h exp=%h", {a_vld, a_instr, a_ipc, a_pcn, a_fault},
                           {1'b0, 32'h0, 8'h00, 8'h04, 1'b0});
    end
    checks++;
    if ({b_vld, b_instr, b_ipc, b_pcn, b_fault} !== {1'b0, 64'h0, 8'h00, 8'h28, 1'b0}) begin
      failures++; $display("FAIL reset_b got=%h exp=%h", {b_vld, b_instr, b_ipc, b_pcn, b_fault},
                           {1'b0, 64'h0, 8'h00, 8'h28, 1'b0});
    end
  endtask

  task automatic test_load();
    logic [7:0] head [4] = '{8'h02, 8'h00, 8'h09, 8'h11};
    reset = 1'b1; prog_en = 1'b1; prog_we = 1'b1; instr_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      prog_addr = 8'(a);
      if (a < 4) prog_data = head[a];
      else if (a >= 'hF8) prog_data = 8'(8'h10 + a - 'hF8);
      else prog_data = 8'($urandom);
      redirect_valid = 1'($urandom); redirect_pc = 8'($urandom);
      tick();
      if (a % 64 == 0) begin
        checks++;
        if ({a_vld, b_vld, a_pcn, b_pcn} !== {1'b0, 1'b0, 8'h04, 8'h28}) begin
          failures++; $display("FAIL load_idle got=%h exp=%h", {a_vld, b_vld, a_pcn, b_pcn},
                               {1'b0, 1'b0, 8'h04, 8'h28});
        end
      end
    end
    prog_we = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_seq();
    prog_en = 1'b0; instr_ready = 1'b1;
    tick();  // enters FETCH
    checks++;
    if (a_vld !== 1'b0) begin failures++; $display("FAIL seq_entry got=%b exp=0", a_vld); end
    tick();
    checks++;
    if ({a_vld, a_instr, a_ipc} !== {1'b1, 32'h11090002, 8'h00}) begin
      failures++; $display("FAIL seq_first got=%h exp=%h", {a_vld, a_instr, a_ipc}, {1'b1, 32'h11090002, 8'h00});
    end
    checks++;
    if ({b_vld, b_instr, b_ipc, b_pcn} !== {1'b1, expb()[80:17], 8'h20, 8'h30}) begin
      failures++; $display("FAIL seq_first_b got=%h exp=%h", {b_vld, b_ipc, b_pcn}, {1'b1, 8'h20, 8'h30});
    end
    tick();
    checks++;
    if ({a_ipc, b_ipc} !== {8'h04, 8'h28}) begin
      failures++; $display("FAIL seq_second got=%h exp=%h", {a_ipc, b_ipc}, {8'h04, 8'h28});
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if ({a_vld, a_ipc, a_pcn, b_ipc} !== {1'b1, 8'h04, 8'h0C, 8'h28}) begin
        failures++; $display("FAIL stall_hold got=%h exp=%h", {a_vld, a_ipc, a_pcn, b_ipc}, {1'b1, 8'h04, 8'h0C, 8'h28});
      end
      checks++;
      if ({a_vld, a_instr, a_ipc, a_pcn, a_fault} !== expa()) begin
        failures++; $display("FAIL stall_model got=%h exp=%h", {a_vld, a_instr, a_ipc, a_pcn, a_fault}, expa());
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if ({a_ipc, b_ipc} !== {8'h08, 8'h30}) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", {a_ipc, b_ipc}, {8'h08, 8'h30});
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick();
    checks++;
    if ({a_vld, b_vld} !== 2'b00) begin failures++; $display("FAIL redir_bubble got=%b exp=00", {a_vld, b_vld}); end
    redirect_valid = 1'b0; instr_ready = 1'b1;
    tick();
    checks++;
    if ({a_vld, a_ipc, b_vld, b_ipc} !== {1'b1, 8'h10, 1'b1, 8'h10}) begin
      failures++; $display("FAIL redir_target got=%h exp=%h", {a_vld, a_ipc, b_vld, b_ipc}, {1'b1, 8'h10, 1'b1, 8'h10});
    end
    redirect_valid = 1'b1; redirect_pc = 8'h40;  // same cycle as instr_ready=1
    tick();
    checks++;
    if ({a_vld, b_vld} !== 2'b00) begin failures++; $display("FAIL redir_prio got=%b exp=00", {a_vld, b_vld}); end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({a_ipc, b_ipc} !== {8'h40, 8'h40}) begin
      failures++; $display("FAIL redir_prio_target got=%h exp=%h", {a_ipc, b_ipc}, {8'h40, 8'h40});
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({a_instr, a_ipc, a_pcn} !== {32'h13121110, 8'hF8, 8'h00}) begin
      failures++; $display("FAIL wrap_a_f8 got=%h exp=%h", {a_instr, a_ipc, a_pcn}, {32'h13121110, 8'hF8, 8'h00});
    end
    checks++;
    if ({b_instr, b_ipc, b_pcn} !== {64'h1716151413121110, 8'hF8, 8'h08}) begin
      failures++; $display("FAIL wrap_b_f8 got=%h exp=%h", {b_instr, b_ipc, b_pcn}, {64'h1716151413121110, 8'hF8, 8'h08});
    end
    tick();
    checks++;
    if ({a_instr, a_ipc, a_pcn, b_ipc} !== {32'h17161514, 8'hFC, 8'h04, 8'h00}) begin
      failures++; $display("FAIL wrap_fc got=%h exp=%h", {a_instr, a_ipc, a_pcn, b_ipc}, {32'h17161514, 8'hFC, 8'h04, 8'h00});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      instr_ready    = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 8) == 0;
      redirect_pc    = {5'($urandom), 3'b000};
      prog_en        = ($urandom % 50) == 0;
      prog_we        = 1'($urandom);
      prog_addr      = 8'($urandom);
      prog_data      = 8'($urandom);
      tick();
      checks++;
      if ({a_vld, a_instr, a_ipc, a_pcn, a_fault} !== expa()) begin
        failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", c, {a_vld, a_instr, a_ipc, a_pcn, a_fault}, expa());
      end
      checks++;
      if ({b_vld, b_instr, b_ipc, b_pcn, b_fault} !== expb()) begin
        failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", c, {b_vld, b_instr, b_ipc, b_pcn, b_fault}, expb());
      end
    end
    prog_en = 1'b0; prog_we = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1; redirect_pc = 8'h04;  // aligned for a, not for b
    tick();
    checks++;
    if ({a_fault, b_fault, b_vld} !== 3'b010) begin
      failures++; $display("FAIL fault_b_only got=%b exp=010", {a_fault, b_fault, b_vld});
    end
    redirect_pc = 8'h06;
    tick();
    checks++;
    if ({a_fault, a_vld, b_fault} !== 3'b101) begin
      failures++; $display("FAIL fault_a got=%b exp=101", {a_fault, a_vld, b_fault});
    end
    redirect_pc = 8'h10;
    repeat (3) begin
      tick();
      checks++;
      if ({a_vld, b_vld, a_fault, b_fault} !== 4'b0011) begin
        failures++; $display("FAIL fault_halt got=%b exp=0011", {a_vld, b_vld, a_fault, b_fault});
      end
    end
    redirect_valid = 1'b0; prog_en = 1'b1;
    tick();
    checks++;
    if ({a_fault, b_fault, a_pcn, b_pcn} !== {2'b11, 8'h04, 8'h28}) begin
      failures++; $display("FAIL fault_to_load got=%h exp=%h", {a_fault, b_fault, a_pcn, b_pcn}, {2'b11, 8'h04, 8'h28});
    end
    prog_en = 1'b0;
    repeat (3) tick();
    checks++;
    if ({a_vld, a_fault, b_fault} !== 3'b111) begin
      failures++; $display("FAIL fault_sticky got=%b exp=111", {a_vld, a_fault, b_fault});
    end
    checks++;
    if ({b_vld, b_instr, b_ipc, b_pcn, b_fault} !== expb()) begin
      failures++; $display("FAIL fault_model_b got=%h exp=%h", {b_vld, b_instr, b_ipc, b_pcn, b_fault}, expb());
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    repeat (3) tick();
    #3 reset = 1'b0;  // well between edges
    #1;
    checks++;
    if ({a_vld, b_vld, a_fault, b_fault, a_pcn, b_pcn, a_ipc} !== {4'b0000, 8'h04, 8'h28, 8'h00}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", {a_vld, b_vld, a_fault, b_fault, a_pcn, b_pcn, a_ipc},
                           {4'b0000, 8'h04, 8'h28, 8'h00});
    end
    tick();
    reset = 1'b1;
    repeat (2) tick();  // LOAD -> FETCH -> first word from preserved memory
    checks++;
    if ({a_vld, a_instr, a_ipc, a_pcn, a_fault} !== expa()) begin
      failures++; $display("FAIL after_reset_a got=%h exp=%h", {a_vld, a_instr, a_ipc, a_pcn, a_fault}, expa());
    end
    checks++;
    if ({b_vld, b_instr, b_ipc, b_pcn, b_fault} !== expb()) begin
      failures++; $display("FAIL after_reset_b got=%h exp=%h", {b_vld, b_instr, b_ipc, b_pcn, b_fault}, expb());
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_load();
    test_seq();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage: PC register, byte-addressed little-endian instruction memory with a load port, and a registered instruction output with a valid/ready handshake. Supports sequential fetch, branch/jump redirect with flush, programmable reset PC, and a sticky misalignment fault. Sits between the program loader and the decode stage of the MIPS datapath.

## Interface
- DATA_W, 32, instruction width in bits; multiple of 8.
- ADDR_W, 8, byte-address width; memory depth is 2^ADDR_W bytes.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- prog_en  input  1  holds unit in LOAD; enables byte writes.
- prog_we  input  1  byte write strobe, honoured only while prog_en=1.
- prog_addr  input  ADDR_W  byte address for write.
- prog_data  input  8  byte to write.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDR_W  redirect target byte address.
- instr_valid  output  1  instr/instr_pc hold a valid word.
- instr_ready  input  1  decode accepts the word this cycle.
- instr  output  DATA_W  fetched instruction.
- instr_pc  output  ADDR_W  byte address of instr.
- pc_next  output  ADDR_W  current PC + DATA_W/8 (combinational, modulo 2^ADDR_W).
- fault  output  1  sticky misaligned-redirect flag.

## Operation
- FSM states: LOAD, FETCH, HALT. Reset enters LOAD.
- LOAD: instr_valid=0; prog_we=1 writes prog_data to mem[prog_addr]. Leaves to FETCH on first edge with prog_en=0; PC=RESET_PC on entry to FETCH. prog_en=1 in FETCH returns to LOAD, clears instr_valid, reloads PC=RESET_PC.
- Read: word at PC assembled little-endian: byte PC+k → bits [8k+7:8k], k=0..DATA_W/8-1; byte addresses wrap modulo 2^ADDR_W.
- FETCH, load condition: (!instr_valid || instr_ready) && !redirect_valid. On load: instr<=word(PC), instr_pc<=PC, instr_valid<=1, PC<=pc_next.
- FETCH, instr_valid && !instr_ready && !redirect_valid: all outputs and PC hold.
- Redirect (FETCH): instr_valid<=0 (flush, even if instr_ready=1 same cycle; that word is still considered consumed by decode), PC<=redirect_pc. Redirect has priority over load.
- redirect_pc with low log2(DATA_W/8) bits nonzero: enter HALT, fault<=1, instr_valid<=0, PC holds. HALT exits only by reset or prog_en=1 (to LOAD; fault stays 1 until reset).
- PC increment wraps modulo 2^ADDR_W (max word address → 0).
- redirect_valid ignored in LOAD and HALT. Memory contents are not reset.

## Timing
- Reset values: instr_valid=0, instr=0, instr_pc=0, fault=0, PC=RESET_PC, state=LOAD; pc_next=RESET_PC+DATA_W/8.
- Fetch latency 1 cycle: first edge in FETCH with ready path open sets instr_valid=1 with word(RESET_PC).
- Sustained throughput 1 word/cycle while instr_ready=1.
- Redirect penalty: one bubble cycle (instr_valid=0), target word valid at the next edge.
- Memory write in LOAD visible to a read on the following cycle.
- Reset asserted mid-fetch: outputs go to reset values immediately, not at clock edge.

## Structure
- Shared package fetch_pkg: state encoding (LOAD/FETCH/HALT), BYTES_PER_WORD = DATA_W/8, alignment-mask function.
- One sub-module: byte_rom — 2^ADDR_W x 8 array, synchronous byte write, combinational little-endian word read with wrap. Top holds FSM, PC, output register.

## Test plan
- Load bytes 0x02,0x00,0x09,0x11 at 0..3, drop prog_en, instr_ready=1 → one cycle later instr=0x11090002, instr_pc=0; next cycle instr_pc=4.
- Hold instr_ready=0 for 3 cycles with instr_valid=1 → instr, instr_pc, PC unchanged; release → next word at pc+4 next cycle.
- redirect_valid with redirect_pc=0x10 while instr_ready=0 → instr_valid=0 next cycle, then instr_pc=0x10; redirect and instr_ready same cycle → redirect wins.
- ADDR_W=8, fetch at 0xFC → word bytes from 0xFC..0xFF, pc_next=0x00; word at 0xFE-style wrap read via DATA_W=64 from 0xF8 spans 0xF8..0xFF.
- redirect_pc=0x06 → fault=1, instr_valid=0, further redirects ignored; prog_en=1 → LOAD, fault still 1; reset → fault=0.
- Assert reset asynchronously between edges during streaming → instr_valid=0 immediately, PC=RESET_PC (test RESET_PC=0x20).
